mem_access_unit: RTL and testbench

Data-memory responder at the far end of the EX/MEM pipeline register: consumes the registered load/store request (`ram_*_ex`), formats byte lanes, and runs a valid/ready transaction on the data-memory bus. It holds the pipeline through `stall_n` until the access completes. It returns sign- or zero-extended load data to write-back. It is the counterpart that answers the memory requests launched by the decode/execute stage.

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the memory (slave):
// a valid/ready request channel and a valid-only read response channel.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              bus_req;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory responder for the EX/MEM register: formats byte lanes, runs the bus
// transaction and stalls the pipeline until done. MEM_MISALIGN_CHECK_EN enables misalignment traps.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] instr_ex,
  input  logic        ram_load_access_ex,
  input  logic        ram_store_access_ex,
  input  logic [31:0] ram_load_addr_ex,
  input  logic [31:0] ram_store_addr_ex,
  input  logic [31:0] ram_store_data_ex,
  output logic        stall_n,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign_err,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_stall_n;
  logic              w_access;
  logic              w_is_load;
  logic              w_start;
  logic              w_misalign;
  logic [2:0]        w_funct3;
  logic [31:0]       w_addr;
  logic              w_unused_bits;

  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_wstrb;
  logic              r_load_valid;
  logic [31:0]       r_load_data;
  logic              r_is_load;
  logic [2:0]        r_funct3;
  logic [1:0]        r_ofs;
  logic              r_flushed;

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] ofs);
    case (f3)
      3'b000:  return 4'b0001 << ofs;
      3'b001:  return 4'b0011 << {ofs[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] ofs,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    logic [15:0] h;
    sh = rd >> {ofs, 3'b000};
    h  = ofs[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h000000, sh[7:0]};
      3'b101:  return {16'h0000, h};
      default: return rd;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misalign_err;

  function automatic logic is_misaligned(input logic is_ld, input logic [2:0] f3,
                                         input logic [1:0] ofs);
    logic byte_acc;
    logic half_acc;
    byte_acc = is_ld ? (f3[1:0] == 2'b00 && !f3[2] || f3 == 3'b100) : (f3 == 3'b000);
    half_acc = is_ld ? (f3 == 3'b001 || f3 == 3'b101) : (f3 == 3'b001);
    if (byte_acc)      return 1'b0;
    else if (half_acc) return ofs[0];
    else               return (ofs != 2'b00);
  endfunction

  assign w_misalign   = is_misaligned(w_is_load, w_funct3, w_addr[1:0]);
  assign misalign_err = r_misalign_err;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // A simultaneous load and store resolves to the load; the store is dropped.
  assign w_is_load     = ram_load_access_ex;
  assign w_access      = ram_load_access_ex | ram_store_access_ex;
  assign w_start       = w_access & ~flush;
  assign w_funct3      = instr_ex[14:12];
  assign w_addr        = w_is_load ? ram_load_addr_ex : ram_store_addr_ex;
  assign w_unused_bits = ^{instr_ex[31:15], instr_ex[11:0]};

  assign stall_n       = w_stall_n | ~rst_n;
  assign load_valid    = r_load_valid;
  assign load_data     = r_load_data;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_wstrb = r_bus_wstrb;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and pipeline stall decode.
  always_comb begin
    w_next_state = r_state;
    w_stall_n    = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_stall_n    = 1'b0;
          w_next_state = w_misalign ? DONE : REQ;
        end else begin
          w_stall_n    = 1'b1;
          w_next_state = IDLE;
        end
      end
      REQ: begin
        w_stall_n = 1'b0;
        if (bus.bus_ready)  w_next_state = r_is_load ? RESP : DONE;
        else if (flush)     w_next_state = IDLE;
        else                w_next_state = REQ;
      end
      RESP: begin
        w_stall_n = 1'b0;
        if (bus.bus_rvalid) w_next_state = DONE;
        else                w_next_state = RESP;
      end
      DONE: begin
        w_stall_n    = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_stall_n    = 1'b1;
        w_next_state = IDLE;
      end
    endcase
  end

  // Bus request registers, access context and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= {ADDR_W{1'b0}};
      r_bus_wdata  <= 32'h0000_0000;
      r_bus_wstrb  <= 4'b0000;
      r_load_valid <= 1'b0;
      r_load_data  <= 32'h0000_0000;
      r_is_load    <= 1'b0;
      r_funct3     <= 3'b000;
      r_ofs        <= 2'b00;
      r_flushed    <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
    end else begin
      r_load_valid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_is_load <= w_is_load;
            r_funct3  <= w_funct3;
            r_ofs     <= w_addr[1:0];
            r_flushed <= 1'b0;
            if (w_misalign) begin
`ifdef MEM_MISALIGN_CHECK_EN
              r_misalign_err <= 1'b1;
`endif
            end else begin
              r_bus_req   <= 1'b1;
              r_bus_we    <= ~w_is_load;
              r_bus_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
              r_bus_wdata <= w_is_load ? 32'h0000_0000 : store_data(w_funct3, ram_store_data_ex);
              r_bus_wstrb <= w_is_load ? 4'b0000 : store_strb(w_funct3, w_addr[1:0]);
            end
          end
        end
        REQ: begin
          // A flush that coincides with the handshake must still finish the bus transfer.
          if (bus.bus_ready) begin
            r_bus_req <= 1'b0;
            if (flush) r_flushed <= 1'b1;
          end else if (flush) begin
            r_bus_req <= 1'b0;
          end
        end
        RESP: begin
          if (flush) r_flushed <= 1'b1;
          if (bus.bus_rvalid && !r_flushed && !flush) begin
            r_load_data  <= load_fmt(r_funct3, r_ofs, bus.bus_rdata);
            r_load_valid <= 1'b1;
          end
        end
        DONE: begin
          r_flushed <= 1'b0;
        end
        default: begin
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random loads/stores against a
// size/offset reference model, plus flush, stray rvalid and asynchronous reset scenarios.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] instr_ex;
  logic        ram_load_access_ex;
  logic        ram_store_access_ex;
  logic [31:0] ram_load_addr_ex;
  logic [31:0] ram_store_addr_ex;
  logic [31:0] ram_store_data_ex;
  logic        stall_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_ld = 32'h0;
  bit chk_en;

  mem_access_unit_if #(.ADDR_W(32)) bus_if ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush               (flush),
    .instr_ex            (instr_ex),
    .ram_load_access_ex  (ram_load_access_ex),
    .ram_store_access_ex (ram_store_access_ex),
    .ram_load_addr_ex    (ram_load_addr_ex),
    .ram_store_addr_ex   (ram_store_addr_ex),
    .ram_store_data_ex   (ram_store_data_ex),
    .stall_n             (stall_n),
    .load_valid          (load_valid),
    .load_data           (load_data),
    .misalign_err        (misalign_err),
    .bus                 (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Access size in bytes as defined by funct3.
  function automatic int ref_size(input bit is_load, input logic [2:0] f3);
    if (is_load) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input bit sgn, input int size, input int eff,
                                           input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * eff);
    if (size == 1) begin
      v = v & 32'h0000_00FF;
      if (sgn && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v & 32'h0000_FFFF;
      if (sgn && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic clear_inputs();
    ram_load_access_ex  = 1'b0;
    ram_store_access_ex = 1'b0;
    flush               = 1'b0;
    bus_if.bus_ready    = 1'b0;
    bus_if.bus_rvalid   = 1'b0;
  endtask

  // One access through a bus model with programmable ready delay and read latency.
  task automatic do_access(input string name, input bit is_load, input bit both,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int rdy_dly, input int rv_lat);
    int size, eff, a_lo, exp_stall, stalls, lv, me, reqc, cyc, hs_cyc, hs_reqc;
    bit mis, done, sgn;
    logic [31:0] exp_ld, exp_wd, instr, got_ld, f_addr, f_wd, h_addr, h_wd;
    logic [3:0]  exp_st, f_st, h_st;
    logic        h_we;
    size      = ref_size(is_load, f3);
    a_lo      = int'(addr[1:0]);
    eff       = a_lo - (a_lo % size);
    mis       = chk_en && ((a_lo % size) != 0);
    sgn       = is_load && (f3 == 3'd0 || f3 == 3'd1);
    exp_ld    = ref_load(sgn, size, eff, rdata);
    exp_st    = 4'(((1 << size) - 1) << eff);
    if (size == 1)      exp_wd = {24'h0, sdata[7:0]} * 32'h0101_0101;
    else if (size == 2) exp_wd = {16'h0, sdata[15:0]} * 32'h0001_0001;
    else                exp_wd = sdata;
    exp_stall = mis ? 1 : 2 + rdy_dly + (is_load ? rv_lat : 0);

    instr = $urandom;
    instr[14:12] = f3;
    instr_ex            = instr;
    ram_load_access_ex  = is_load;
    ram_store_access_ex = !is_load || both;
    ram_load_addr_ex    = is_load ? addr : $urandom;
    ram_store_addr_ex   = is_load ? $urandom : addr;
    ram_store_data_ex   = is_load ? $urandom : sdata;

    stalls = 0; lv = 0; me = 0; reqc = 0; cyc = 0; hs_cyc = -1; hs_reqc = 0; done = 0;
    got_ld = 32'h0; f_addr = 32'h0; f_wd = 32'h0; f_st = 4'h0;
    h_addr = 32'h0; h_wd = 32'h0; h_st = 4'h0; h_we = 1'b0;
    while (!done && cyc < 200) begin
      bus_if.bus_ready  = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = $urandom;
      if (bus_if.bus_req === 1'b1) begin
        if (reqc == 0) begin
          f_addr = bus_if.bus_addr; f_wd = bus_if.bus_wdata; f_st = bus_if.bus_wstrb;
        end
        if (reqc >= rdy_dly && hs_cyc < 0) begin
          bus_if.bus_ready = 1'b1;
          hs_cyc = cyc; hs_reqc = reqc;
          h_addr = bus_if.bus_addr; h_wd = bus_if.bus_wdata;
          h_st = bus_if.bus_wstrb; h_we = bus_if.bus_we;
        end
        reqc++;
      end
      if (hs_cyc >= 0 && is_load && cyc == hs_cyc + rv_lat) begin
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = rdata;
      end
      #1;
      if (load_valid === 1'b1) lv++;
      if (misalign_err === 1'b1) me++;
      if (stall_n === 1'b0) stalls++;
      else begin
        done = 1;
        got_ld = load_data;
      end
      @(negedge clk);
      cyc++;
    end
    clear_inputs();
    #1;
    if (load_valid === 1'b1) lv++;

    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: stall_n never released after %0d cycles", name, cyc);
    end
    total++;
    if (stalls != exp_stall) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stall);
    end
    total++;
    if (lv != ((is_load && !mis) ? 1 : 0)) begin
      bad++;
      $display("FAIL %s load_valid_pulses: got %0d expected %0d", name, lv,
               (is_load && !mis) ? 1 : 0);
    end
    total++;
    if (me != (mis ? 1 : 0)) begin
      bad++;
      $display("FAIL %s misalign_pulses: got %0d expected %0d", name, me, mis ? 1 : 0);
    end
    total++;
    if (is_load && !mis) begin
      if (got_ld !== exp_ld) begin
        bad++;
        $display("FAIL %s load_data: got %08h expected %08h", name, got_ld, exp_ld);
      end
      model_ld = exp_ld;
    end else if (got_ld !== model_ld) begin
      bad++;
      $display("FAIL %s load_data_kept: got %08h expected %08h", name, got_ld, model_ld);
    end
    if (mis) begin
      total++;
      if (reqc != 0) begin
        bad++;
        $display("FAIL %s misaligned_req: got %0d req cycles expected 0", name, reqc);
      end
    end else begin
      total++;
      if (h_addr !== (addr & 32'hFFFF_FFFC) || h_we !== !is_load) begin
        bad++;
        $display("FAIL %s addr_we: got %08h/%0b expected %08h/%0b", name, h_addr, h_we,
                 addr & 32'hFFFF_FFFC, !is_load);
      end
      total++;
      if (h_st !== (is_load ? 4'b0000 : exp_st)) begin
        bad++;
        $display("FAIL %s wstrb: got %04b expected %04b", name, h_st,
                 is_load ? 4'b0000 : exp_st);
      end
      if (!is_load) begin
        total++;
        if (h_wd !== exp_wd) begin
          bad++;
          $display("FAIL %s wdata: got %08h expected %08h", name, h_wd, exp_wd);
        end
      end
      if (hs_reqc > 0) begin
        total++;
        if (f_addr !== h_addr || f_wd !== h_wd || f_st !== h_st) begin
          bad++;
          $display("FAIL %s req_stable: got %08h/%08h/%04b expected %08h/%08h/%04b", name,
                   h_addr, h_wd, h_st, f_addr, f_wd, f_st);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (bus_if.bus_req !== 1'b0 || bus_if.bus_we !== 1'b0 || bus_if.bus_wstrb !== 4'b0 ||
        bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
      bad++;
      $display("FAIL %s bus_outputs: got req=%0b we=%0b strb=%04b addr=%08h wdata=%08h expected all 0",
               name, bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr,
               bus_if.bus_wdata);
    end
    total++;
    if (load_valid !== 1'b0 || load_data !== 32'h0 || misalign_err !== 1'b0) begin
      bad++;
      $display("FAIL %s load_outputs: got lv=%0b data=%08h me=%0b expected 0/0/0", name,
               load_valid, load_data, misalign_err);
    end
    total++;
    if (stall_n !== 1'b1) begin
      bad++;
      $display("FAIL %s stall_n: got %0b expected 1", name, stall_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    #2;
    rst_n = 1'b0;
    ram_load_access_ex = 1'b1;
    ram_load_addr_ex   = 32'h0000_4000;
    instr_ex           = 32'h0000_2000;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    model_ld = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_access("sb_1003", 1'b0, 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1);
    do_access("lb_2001", 1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_80FF, 0, 1);
    do_access("lbu_2001", 1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_80FF, 0, 1);
    do_access("sh_hi", 1'b0, 1'b0, 3'b001, 32'h0000_0A02, 32'h1234_BEEF, 32'h0, 1, 1);
    do_access("lh_hi", 1'b1, 1'b0, 3'b001, 32'h0000_0A02, 32'h0, 32'h9ABC_0011, 0, 1);
    do_access("lw_wait", 1'b1, 1'b0, 3'b010, 32'h0000_5550, 32'h0, 32'hCAFE_F00D, 3, 2);
    do_access("lw_3002", 1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h1234_5678, 0, 1);
    do_access("ld_st_both", 1'b1, 1'b1, 3'b101, 32'h0000_7776, 32'h0, 32'h8001_7FFE, 2, 1);
  endtask

  task automatic test_random_back_to_back();
    bit ld, both;
    logic [2:0] f3;
    for (int i = 0; i < 40; i++) begin
      ld   = ($urandom_range(0, 1) == 1);
      both = ld && ($urandom_range(0, 3) == 0);
      f3   = 3'($urandom_range(0, 7));
      do_access("rand", ld, both, f3, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(1, 3));
    end
  endtask

  task automatic test_stray_rvalid();
    int lv = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = $urandom;
      @(negedge clk);
      #1;
      if (load_valid === 1'b1) lv++;
    end
    bus_if.bus_rvalid = 1'b0;
    total++;
    if (lv != 0 || load_data !== model_ld) begin
      bad++;
      $display("FAIL stray_rvalid: got lv=%0d data=%08h expected 0/%08h", lv, load_data, model_ld);
    end
  endtask

  task automatic test_flush_req();
    int lv = 0;
    @(negedge clk);
    instr_ex = 32'h0000_2003; ram_load_addr_ex = 32'h0000_6000; ram_load_access_ex = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus_if.bus_req !== 1'b1) begin
      bad++;
      $display("FAIL flush_req_start: got bus_req=%0b expected 1", bus_if.bus_req);
    end
    flush = 1'b1;
    #1;
    total++;
    if (stall_n !== 1'b0) begin
      bad++;
      $display("FAIL flush_req_stall: got %0b expected 0", stall_n);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (bus_if.bus_req !== 1'b0) begin
      bad++;
      $display("FAIL flush_req_drop: got bus_req=%0b expected 0", bus_if.bus_req);
    end
    for (int i = 0; i < 4; i++) begin
      if (load_valid === 1'b1 || bus_if.bus_req === 1'b1) lv++;
      @(negedge clk);
    end
    total++;
    if (lv != 0 || stall_n !== 1'b1) begin
      bad++;
      $display("FAIL flush_req_quiet: got %0d events stall_n=%0b expected 0/1", lv, stall_n);
    end
  endtask

  task automatic test_flush_resp();
    @(negedge clk);
    instr_ex = 32'h0000_2003; ram_load_addr_ex = 32'h0000_6100; ram_load_access_ex = 1'b1;
    @(negedge clk);
    bus_if.bus_ready = 1'b1;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    flush = 1'b1;
    #1;
    total++;
    if (stall_n !== 1'b0) begin
      bad++;
      $display("FAIL flush_resp_hold: got stall_n=%0b expected 0", stall_n);
    end
    @(negedge clk);
    clear_inputs();
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h5A5A_1234;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    #1;
    total++;
    if (stall_n !== 1'b1 || load_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_resp_done: got stall_n=%0b lv=%0b expected 1/0", stall_n, load_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (load_valid !== 1'b0 || bus_if.bus_req !== 1'b0) begin
      bad++;
      $display("FAIL flush_resp_after: got lv=%0b req=%0b expected 0/0", load_valid, bus_if.bus_req);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    instr_ex = 32'h0000_2003; ram_load_addr_ex = 32'h0012_3450; ram_load_access_ex = 1'b1;
    @(negedge clk);
    bus_if.bus_ready = 1'b1;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    model_ld = 32'h0;
    @(negedge clk);
    do_access("post_rst_lw", 1'b1, 1'b0, 3'b010, 32'h0000_8008, 32'h0, 32'h0BAD_CAFE, 1, 1);
    do_access("post_rst_sh", 1'b0, 1'b0, 3'b001, 32'h0000_8010, 32'hFFFF_8421, 32'h0, 0, 1);
  endtask

  initial begin
`ifdef MEM_MISALIGN_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    instr_ex          = 32'h0;
    ram_load_addr_ex  = 32'h0;
    ram_store_addr_ex = 32'h0;
    ram_store_data_ex = 32'h0;
    bus_if.bus_rdata  = 32'h0;
    test_reset();
    test_directed();
    test_random_back_to_back();
    test_stray_rvalid();
    test_flush_req();
    test_flush_resp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
